// File: rtl/vpu_out_deskew.sv
// -----------------------------------------------------------------------------
// vpu_out_deskew
//
// Re-aligns the diagonally skewed per-lane int8 results of the VPU channel
// array into full rows for the unified-buffer writeback. Lane i of a row
// arrives i cycles after lane 0 and cannot be stalled, so every lane writes
// into its own FIFO. As soon as every lane holds at least one element, the
// heads of all lanes are popped together into one packed output word.
//
// Optional feature (macro VPU_DESKEW_STALL_CNT_EN):
//   Adds the stall_cnt output. It counts the cycles in which a row is waiting
//   on the consumer, and it saturates at 16'hFFFF.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   rst            asynchronous active-low reset
//   vpu_out_valid  per-lane push strobe (never back-pressured)
//   vpu_out        per-lane data, unpacked array [CHANNEL_WIDTH]
//   row_clear      synchronous flush of all lanes plus tile restart
//   out_valid      packed row available
//   out_ready      consumer accepts the row
//   out_data       packed row; lane i occupies [i*O_WIDTH +: O_WIDTH]
//   out_row_idx    row index within the tile of the row on out_data
//   out_last       out_valid for the final row of a tile
//   overflow_err   sticky; a lane was pushed while its FIFO was full
//   lane_empty     per-lane FIFO empty flags
//   stall_cnt      (optional) saturating count of out_valid & !out_ready
//
// Handshake: a row transfers on a rising edge where out_valid && out_ready.
// Once out_valid is high, it stays high and out_data, out_row_idx and
// out_last hold steady until that transfer happens. A new row can load in the
// same cycle as a transfer, so throughput is one row per cycle.
// -----------------------------------------------------------------------------
module vpu_out_deskew #(
  parameter int O_WIDTH       = 8,
  parameter int CHANNEL_WIDTH = 16,
  parameter int BATCH_SIZE    = 16,
  parameter int FIFO_DEPTH    = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNEL_WIDTH-1:0]           vpu_out_valid,
  input  logic [O_WIDTH-1:0]                 vpu_out [CHANNEL_WIDTH],
  input  logic                               row_clear,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [O_WIDTH*CHANNEL_WIDTH-1:0]   out_data,
  output logic [$clog2(BATCH_SIZE)-1:0]      out_row_idx,
  output logic                               out_last,
  output logic                               overflow_err,
  output logic [CHANNEL_WIDTH-1:0]           lane_empty
`ifdef VPU_DESKEW_STALL_CNT_EN
  ,
  output logic [15:0]                        stall_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(BATCH_SIZE);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [RW-1:0] IDX_ONE  = RW'(1);
  localparam logic [RW-1:0] IDX_LAST = RW'(BATCH_SIZE - 1);

  // Each pointer carries one extra wrap bit. This lets full and empty be told
  // apart without a separate occupancy counter.
  logic [AW:0]          wr_ptr [CHANNEL_WIDTH];
  logic [AW:0]          rd_ptr [CHANNEL_WIDTH];
  logic [O_WIDTH-1:0]   mem    [CHANNEL_WIDTH][FIFO_DEPTH];

  logic [CHANNEL_WIDTH-1:0]         lane_full;
  logic [CHANNEL_WIDTH-1:0]         push_en;
  logic [CHANNEL_WIDTH-1:0]         push_drop;
  logic [O_WIDTH*CHANNEL_WIDTH-1:0] row_head;
  logic                             row_ready;
  logic                             load;
  logic                             xfer;

  always_comb begin
    lane_empty = '0;
    lane_full  = '0;
    push_en    = '0;
    push_drop  = '0;
    row_head   = '0;
    for (int i = 0; i < CHANNEL_WIDTH; i++) begin
      lane_empty[i] = (wr_ptr[i] == rd_ptr[i]);
      lane_full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                      (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      row_head[i*O_WIDTH +: O_WIDTH] = mem[i][rd_ptr[i][AW-1:0]];
    end
    row_ready = ~|lane_empty;
    load      = row_ready && (!out_valid || out_ready);
    xfer      = out_valid && out_ready;
    // A full lane that pops in this cycle frees its slot in time for the
    // write. Only a push into a full lane that is not popping gets dropped.
    for (int i = 0; i < CHANNEL_WIDTH; i++) begin
      push_en[i]   = vpu_out_valid[i] && (!lane_full[i] || load);
      push_drop[i] = vpu_out_valid[i] && lane_full[i] && !load;
    end
  end

  // Storage has no reset. Entries are only read once their pointer shows
  // they were written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNEL_WIDTH; i++) begin
      if (push_en[i] && !row_clear) begin
        mem[i][wr_ptr[i][AW-1:0]] <= vpu_out[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNEL_WIDTH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else if (row_clear) begin
      for (int i = 0; i < CHANNEL_WIDTH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNEL_WIDTH; i++) begin
        if (push_en[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        if (load)       rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_row_idx  <= '0;
      overflow_err <= 1'b0;
    end else if (row_clear) begin
      out_valid    <= 1'b0;
      out_row_idx  <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= row_head;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (xfer) begin
        out_row_idx <= (out_row_idx == IDX_LAST) ? '0 : out_row_idx + IDX_ONE;
      end
      if (|push_drop) overflow_err <= 1'b1;
    end
  end

  assign out_last = out_valid && (out_row_idx == IDX_LAST);

`ifdef VPU_DESKEW_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (row_clear) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vpu_out_deskew.sv
// -----------------------------------------------------------------------------
// tb_vpu_out_deskew
//
// Directed bench for vpu_out_deskew with its default parameters (8-bit lanes,
// 16 lanes, 16-row tiles, 32-entry FIFOs). The drivers push each expected
// packed row, with its row index and last flag, into exp_q when lane 0 of
// that row is issued. A negedge monitor pops and compares on every transfer.
// Directed checks cover reset values, latency, hold under backpressure,
// overflow, row_clear and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_vpu_out_deskew;

  localparam int OW = 8;
  localparam int CW = 16;
  localparam int BS = 16;
  localparam int W  = 1 + 4 + OW*CW;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic [CW-1:0]   vld;
  logic [OW-1:0]   vpu_out [CW];
  logic            row_clear;
  logic            out_valid;
  logic            out_ready;
  logic [OW*CW-1:0] out_data;
  logic [3:0]      out_row_idx;
  logic            out_last;
  logic            overflow_err;
  logic [CW-1:0]   lane_empty;
`ifdef VPU_DESKEW_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  vpu_out_deskew dut (
    .clk           (clk),
    .rst           (rst),
    .vpu_out_valid (vld),
    .vpu_out       (vpu_out),
    .row_clear     (row_clear),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_row_idx   (out_row_idx),
    .out_last      (out_last),
    .overflow_err  (overflow_err),
    .lane_empty    (lane_empty)
`ifdef VPU_DESKEW_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int vectors    = 0;
  int miscompares = 0;
  int exp_idx    = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] val(input int r, input int i);
    return OW'((r + 1) * 16 + i);
  endfunction

  function automatic logic [OW*CW-1:0] build_row(input int r);
    logic [OW*CW-1:0] d;
    d = '0;
    for (int i = 0; i < CW; i++) d[i*OW +: OW] = val(r, i);
    return d;
  endfunction

  task automatic push_exp(input logic [OW*CW-1:0] d);
    exp_q.push_back({(exp_idx == BS-1), 4'(exp_idx), d});
    exp_idx = (exp_idx + 1) % BS;
  endtask

  // Monitor: every accepted row must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_row", {out_last, out_row_idx, out_data}, '0);
        if ({out_last, out_row_idx, out_data} == '0) begin
          miscompares++;
          $display("FAIL unexpected_row: got a zero row, expected no row");
        end
      end else begin
        check("row", {out_last, out_row_idx, out_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n rows with the diagonal skew: lane i carries row (t - i) at step t.
  task automatic send_rows(input int n, input int base);
    for (int t = 0; t < n + CW - 1; t++) begin
      for (int i = 0; i < CW; i++) begin
        int r;
        r = t - i;
        if (r >= 0 && r < n) begin
          vld[i]     = 1'b1;
          vpu_out[i] = val(base + r, i);
        end else begin
          vld[i]     = 1'b0;
          vpu_out[i] = '0;
        end
      end
      if (t < n) push_exp(build_row(base + t));
      tick();
    end
    vld = '0;
  endtask

  task automatic clear_pulse();
    row_clear = 1'b1;
    tick();
    row_clear = 1'b0;
    exp_idx   = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    repeat (3) tick();
    check("drain_empty", W'(exp_q.size()), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b0;
    vld       = '0;
    row_clear = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < CW; i++) vpu_out[i] = '0;
    repeat (3) tick();

    // Reset state
    check("rst_out_valid",    W'(out_valid),    '0);
    check("rst_out_data",     W'(out_data),     '0);
    check("rst_out_row_idx",  W'(out_row_idx),  '0);
    check("rst_out_last",     W'(out_last),     '0);
    check("rst_overflow_err", W'(overflow_err), '0);
    check("rst_lane_empty",   W'(lane_empty),   W'(16'hFFFF));
    rst = 1'b1;
    tick();

    // Single skewed row: lane i = 8'h10+i. The row is valid one cycle after
    // lane 15 is written.
    send_rows(1, 0);
    check("latency_early", W'(out_valid), '0);
    tick();
    check("latency_valid", W'(out_valid), W'(1));
    check("latency_data",  W'(out_data), W'(build_row(0)));
    check("latency_idx",   W'(out_row_idx), '0);
    drain();

    // row_clear in the same cycle as a lane-3 push, with 5 lanes partly filled
    for (int t = 0; t < 5; t++) begin
      vld = '0;
      vld[t] = 1'b1;
      vpu_out[t] = 8'h55;
      tick();
    end
    vld = '0;
    vld[3] = 1'b1;
    vpu_out[3] = 8'h66;
    clear_pulse();
    vld = '0;
    check("clr_lane_empty", W'(lane_empty), W'(16'hFFFF));
    check("clr_out_valid",  W'(out_valid),  '0);
    check("clr_row_idx",    W'(out_row_idx), '0);
    repeat (20) tick();
    check("clr_no_row", W'(out_valid), '0);

    // Full tile plus one: idx 0..15, last on 15, then idx wraps to 0
    send_rows(17, 1);
    drain();

    // Backpressure: three rows arrive while out_ready is low
    out_ready = 1'b0;
    send_rows(3, 20);
    repeat (2) tick();
    check("bp_valid",     W'(out_valid),    W'(1));
    check("bp_data_held", W'(out_data),     W'(build_row(20)));
    check("bp_lanes_hold", W'(lane_empty),  '0);
    check("bp_overflow",  W'(overflow_err), '0);
    out_ready = 1'b1;
    drain();

    // Overflow: lane 0 pushed 33 times while lane 15 stays empty
    clear_pulse();
    for (int k = 0; k < 33; k++) begin
      vld = 16'h0001;
      vpu_out[0] = OW'(8'hA0 + k);
      tick();
      if (k == 31) check("ovf_before", W'(overflow_err), '0);
    end
    vld = '0;
    check("ovf_set",        W'(overflow_err), W'(1));
    check("ovf_lane_empty", W'(lane_empty),   W'(16'hFFFE));
    for (int k = 0; k < 32; k++) begin
      logic [OW*CW-1:0] d;
      d = '0;
      d[0 +: OW] = OW'(8'hA0 + k);
      vld = 16'hFFFE;
      for (int i = 1; i < CW; i++) begin
        vpu_out[i] = OW'(i * 16 + k);
        d[i*OW +: OW] = OW'(i * 16 + k);
      end
      push_exp(d);
      tick();
    end
    vld = '0;
    drain();
    check("ovf_sticky", W'(overflow_err), W'(1));
    clear_pulse();
    check("ovf_cleared", W'(overflow_err), '0);

`ifdef VPU_DESKEW_STALL_CNT_EN
    // Stall counter: 5 cycles held with out_ready low
    clear_pulse();
    out_ready = 1'b0;
    send_rows(1, 40);
    tick();
    check("stall_start", W'(stall_cnt), '0);
    repeat (5) tick();
    check("stall_five", W'(stall_cnt), W'(5));
    out_ready = 1'b1;
    drain();
    clear_pulse();
    check("stall_cleared", W'(stall_cnt), '0);
`endif

    // Asynchronous reset while a row is waiting on the consumer
    out_ready = 1'b0;
    send_rows(1, 50);
    tick();
    check("ar_pre_valid", W'(out_valid), W'(1));
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid",      W'(out_valid),  '0);
    check("ar_data",       W'(out_data),   '0);
    check("ar_lane_empty", W'(lane_empty), W'(16'hFFFF));
    exp_q.delete();
    exp_idx = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    tick();

    // Operation resumes from row 0 after reset
    send_rows(1, 60);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
